// File: rtl/instr_fetch_unit.sv
// Fetch stage: issues in-order instruction memory requests at the current PC and buffers
// returned words with their PCs in a small FIFO feeding decode over valid/ready.
module instr_fetch_unit #(
  parameter int XLEN       = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int MAX_OUT    = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] pc,
  output logic            pc_inc,
  input  logic            redirect,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic [XLEN-1:0] instr,
  output logic [XLEN-1:0] instr_pc
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int OW = $clog2(MAX_OUT + 1);
  localparam int QW = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
  localparam logic [CW:0]   DEPTH_W = (CW+1)'(FIFO_DEPTH);
  localparam logic [OW:0]   MAXO_W  = (OW+1)'(MAX_OUT);
  localparam logic [QW-1:0] QLAST   = QW'(MAX_OUT - 1);

  logic [XLEN-1:0] fifo_word [FIFO_DEPTH];
  logic [XLEN-1:0] fifo_pc   [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [CW-1:0]   count;

  logic [XLEN-1:0] q_pc [MAX_OUT];
  logic [QW-1:0]   q_wr;
  logic [QW-1:0]   q_rd;
  logic [OW-1:0]   outstanding;
  logic [OW-1:0]   discard;

  logic [CW:0] occupancy;
  logic [OW:0] pending;
  logic        fire;
  logic        rsp_take;
  logic        rsp_keep;
  logic        push;
  logic        pop;

  function automatic logic [QW-1:0] q_next(input logic [QW-1:0] p);
    return (p == QLAST) ? '0 : p + 1'b1;
  endfunction

  // Requests are only issued when every outstanding word is guaranteed a FIFO slot,
  // which also keeps a pending request stable until granted.
  always_comb begin
    occupancy   = {1'b0, count} + (CW+1)'(outstanding);
    pending     = {1'b0, outstanding} + {1'b0, discard};
    imem_req    = !rst && !redirect && (occupancy < DEPTH_W) && (pending < MAXO_W);
    imem_addr   = pc;
    fire        = imem_req && imem_gnt;
    pc_inc      = fire;
    rsp_take    = imem_rvalid && (pending != '0);
    rsp_keep    = rsp_take && (discard == '0);
    instr_valid = (count != '0);
    push        = rsp_keep && !redirect;
    pop         = instr_valid && instr_ready && !redirect;
    instr       = instr_valid ? fifo_word[rd_ptr] : '0;
    instr_pc    = instr_valid ? fifo_pc[rd_ptr]   : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_word[i] <= '0;
        fifo_pc[i]   <= '0;
      end
    end else if (redirect) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        fifo_word[wr_ptr] <= imem_rdata;
        fifo_pc[wr_ptr]   <= q_pc[q_rd];
        wr_ptr            <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (push && !pop) begin
        count <= count + 1'b1;
      end else if (!push && pop) begin
        count <= count - 1'b1;
      end
    end
  end

  // A redirect turns every live request into a word to be dropped on return.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_wr        <= '0;
      q_rd        <= '0;
      outstanding <= '0;
      discard     <= '0;
      for (int i = 0; i < MAX_OUT; i++) begin
        q_pc[i] <= '0;
      end
    end else if (redirect) begin
      q_wr        <= '0;
      q_rd        <= '0;
      outstanding <= '0;
      discard     <= discard + outstanding - OW'(rsp_take);
    end else begin
      if (fire) begin
        q_pc[q_wr] <= pc;
        q_wr       <= q_next(q_wr);
      end
      if (rsp_keep) begin
        q_rd <= q_next(q_rd);
      end
      if (rsp_take && (discard != '0)) begin
        discard <= discard - 1'b1;
      end
      if (fire && !rsp_keep) begin
        outstanding <= outstanding + 1'b1;
      end else if (!fire && rsp_keep) begin
        outstanding <= outstanding - 1'b1;
      end
    end
  end

  rvalid_without_request: assert property (
    @(posedge clk) disable iff (rst) imem_rvalid |-> (pending != '0)
  );

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit with a ProgramCounter model and a simple
// in-order instruction memory whose grant and response timing is steered per test.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] pc;
  logic        pc_inc;
  logic        redirect = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [31:0] instr;
  logic [31:0] instr_pc;

  logic [31:0] target = '0;
  logic        rsp_hold = 1'b0;
  logic [31:0] exp_pc;
  logic [31:0] expq[$];
  logic [31:0] rspq[$];
  int          checks = 0;
  int          failures = 0;
  int          grants;
  logic        seen;

  instr_fetch_unit #(.XLEN(32), .FIFO_DEPTH(4), .MAX_OUT(2)) dut (
    .clk(clk), .rst(rst), .pc(pc), .pc_inc(pc_inc), .redirect(redirect),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .instr_pc(instr_pc)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] memWord(input logic [31:0] a);
    return 32'hDEAD_0000 | a;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic gnt, input logic hold, input logic ready,
                               input logic redir, input logic [31:0] tgt);
    imem_gnt    = gnt;
    rsp_hold    = hold;
    instr_ready = ready;
    redirect    = redir;
    target      = tgt;
  endtask

  task automatic resetDut(input logic gnt, input logic hold, input logic ready);
    @(negedge clk);
    rst = 1'b1;
    applyStimulus(gnt, hold, ready, 1'b0, 32'h0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic waitDrain(input string name);
    for (int i = 0; i < 40 && expq.size() != 0; i++) @(negedge clk);
    checkOutput({name, "_drained"}, 32'(expq.size()), 32'h0);
    expq.delete();
    @(negedge clk);
    #1;
    checkOutput({name, "_empty_after"}, {31'h0, instr_valid}, 32'h0);
  endtask

  // ProgramCounter neighbour: load on redirect, +4 on pc_inc.
  always @(posedge clk or posedge rst) begin
    if (rst) pc <= '0;
    else if (redirect) pc <= target;
    else if (pc_inc) pc <= pc + 32'h4;
  end

  // Memory: grants queue an address; the head is presented whenever not held.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      rspq.delete();
      imem_rvalid <= 1'b0;
      imem_rdata  <= '0;
    end else begin
      if (imem_rvalid && rspq.size() > 0) rspq.delete(0);
      if (imem_req && imem_gnt) rspq.push_back(imem_addr);
      if (!rsp_hold && rspq.size() > 0) begin
        imem_rvalid <= 1'b1;
        imem_rdata  <= memWord(rspq[0]);
      end else begin
        imem_rvalid <= 1'b0;
      end
    end
  end

  // Monitor: every accepted head must match the next expected word.
  always @(negedge clk) begin
    #2;
    if (!rst && instr_valid && instr_ready) begin
      if (expq.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL unexpected_instr: got pc 0x%08h while none expected", instr_pc);
      end else begin
        exp_pc = expq.pop_front();
        checkOutput("instr_pc", instr_pc, exp_pc);
        checkOutput("instr", instr, memWord(exp_pc));
      end
    end
  end

  initial begin
    #100000;
    failures++;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    // Streaming with one-cycle memory and an always-ready decoder
    #2 rst = 1'b1;
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
    @(negedge clk);
    #1;
    checkOutput("rst_pc_inc", {31'h0, pc_inc}, 32'h0);
    checkOutput("rst_imem_req", {31'h0, imem_req}, 32'h0);
    checkOutput("rst_instr_valid", {31'h0, instr_valid}, 32'h0);
    checkOutput("rst_instr", instr, 32'h0);
    checkOutput("rst_instr_pc", instr_pc, 32'h0);
    for (int i = 0; i < 6; i++) expq.push_back(32'(i * 4));
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      checkOutput("t1_pc_inc", {31'h0, pc_inc}, 32'h1);
      checkOutput("t1_addr", imem_addr, 32'(i * 4));
      if (i == 1) checkOutput("t1_valid_not_yet", {31'h0, instr_valid}, 32'h0);
      if (i == 2) checkOutput("t1_valid_first", {31'h0, instr_valid}, 32'h1);
    end
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
    waitDrain("t1");

    // Decoder stalled: the buffer fills to exactly four words
    foreach (expq[i]) expq.delete(i);
    expq.push_back(32'h0);  expq.push_back(32'h4);  expq.push_back(32'h8);
    expq.push_back(32'hC);  expq.push_back(32'h10); expq.push_back(32'h14);
    expq.push_back(32'h18);
    resetDut(1'b1, 1'b0, 1'b0);
    grants = 0;
    for (int i = 0; i < 8; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      grants += int'(pc_inc);
    end
    checkOutput("t2_grants", 32'(grants), 32'h4);
    checkOutput("t2_req_off", {31'h0, imem_req}, 32'h0);
    checkOutput("t2_head_held", instr_pc, 32'h0);
    @(negedge clk);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
    #1;
    checkOutput("t2_no_inc_full", {31'h0, pc_inc}, 32'h0);
    @(negedge clk);
    #1;
    checkOutput("t2_refill_inc", {31'h0, pc_inc}, 32'h1);
    checkOutput("t2_refill_addr", imem_addr, 32'h10);
    repeat (3) @(negedge clk);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
    waitDrain("t2");

    // Grant stalled three cycles on a redirected target
    expq.push_back(32'h100);
    resetDut(1'b0, 1'b0, 1'b1);
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 32'h100);
    #1;
    checkOutput("t3_redirect_req", {31'h0, imem_req}, 32'h0);
    checkOutput("t3_redirect_inc", {31'h0, pc_inc}, 32'h0);
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      checkOutput("t3_req_held", {31'h0, imem_req}, 32'h1);
      checkOutput("t3_addr_held", imem_addr, 32'h100);
      checkOutput("t3_no_inc", {31'h0, pc_inc}, 32'h0);
    end
    @(negedge clk);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
    #1;
    checkOutput("t3_gnt_inc", {31'h0, pc_inc}, 32'h1);
    checkOutput("t3_gnt_addr", imem_addr, 32'h100);
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
    #1;
    checkOutput("t3_next_addr", imem_addr, 32'h104);
    waitDrain("t3");

    // Redirect with two requests in flight: both responses are discarded
    expq.push_back(32'h400);
    resetDut(1'b0, 1'b1, 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 32'h20);
    @(negedge clk);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    @(negedge clk);
    #1;
    checkOutput("t4_second_addr", imem_addr, 32'h24);
    checkOutput("t4_second_inc", {31'h0, pc_inc}, 32'h1);
    @(negedge clk);
    #1;
    checkOutput("t4_max_out", {31'h0, imem_req}, 32'h0);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 32'h400);
    @(negedge clk);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
    #1;
    checkOutput("t4_flushed", {31'h0, instr_valid}, 32'h0);
    checkOutput("t4_wait_discard", {31'h0, imem_req}, 32'h0);
    checkOutput("t4_new_addr", imem_addr, 32'h400);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      #1;
      seen = pc_inc;
    end
    checkOutput("t4_req_after_discard", {31'h0, seen}, 32'h1);
    checkOutput("t4_first_addr", imem_addr, 32'h400);
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
    waitDrain("t4");

    // Redirect coinciding with a response and a pop
    expq.push_back(32'h0);
    expq.push_back(32'h800);
    resetDut(1'b1, 1'b1, 1'b0);
    @(negedge clk);
    @(negedge clk);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    #1;
    checkOutput("t5_head_valid", {31'h0, instr_valid}, 32'h1);
    checkOutput("t5_head_pc", instr_pc, 32'h0);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 32'h800);
    #1;
    checkOutput("t5_redirect_req", {31'h0, imem_req}, 32'h0);
    @(negedge clk);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
    #1;
    checkOutput("t5_no_stale", {31'h0, instr_valid}, 32'h0);
    checkOutput("t5_req_one_discard", {31'h0, imem_req}, 32'h1);
    checkOutput("t5_addr", imem_addr, 32'h800);
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
    #1;
    checkOutput("t5_dropped", {31'h0, instr_valid}, 32'h0);
    waitDrain("t5");

    // Asynchronous reset with three buffered words
    resetDut(1'b1, 1'b0, 1'b0);
    repeat (4) @(negedge clk);
    #1;
    checkOutput("t6_pre_valid", {31'h0, instr_valid}, 32'h1);
    checkOutput("t6_pre_pc", instr_pc, 32'h0);
    rst = 1'b1;
    #1;
    checkOutput("t6_pc_inc", {31'h0, pc_inc}, 32'h0);
    checkOutput("t6_imem_req", {31'h0, imem_req}, 32'h0);
    checkOutput("t6_instr_valid", {31'h0, instr_valid}, 32'h0);
    checkOutput("t6_instr", instr, 32'h0);
    checkOutput("t6_instr_pc", instr_pc, 32'h0);
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    checkOutput("t6_stays_empty", {31'h0, instr_valid}, 32'h0);
    waitDrain("t6");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
